// File: rtl/key_event_scheduler.sv
// ============================================================================
// Module   : key_event_scheduler
// Purpose  : Detects key-on/key-off edges on 18 channels and issues them one at
//            a time, in round-robin order, over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_scheduler #(
    parameter int NUM_CH = 18,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [NUM_CH-1:0] key_on,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CH_W-1:0]   ev_channel,
    output logic              ev_key_on,
    output logic              ev_dropped,
    input  logic              dropped_clr,
    output logic              busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [NUM_CH-1:0] r_key;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_pend_type;
    logic [CH_W-1:0]   r_ptr;
    logic              r_ev_valid;
    logic [CH_W-1:0]   r_ev_channel;
    logic              r_ev_key_on;
    logic              r_ev_dropped;

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_drop_vec;
    logic              w_found;
    logic [CH_W-1:0]   w_sel;
    logic              w_grant;
    logic              w_accept;

    // Key changes only become visible on sample-enable cycles.
    assign w_rise = clk_en ? (key_on & ~r_key) : '0;
    assign w_edge = clk_en ? (key_on ^ r_key)  : '0;

    // First pending channel at or after the pointer, wrapping round.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!w_found && r_pend[j]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(j);
            end
        end
    end

    // A same-cycle grant carries the old event away, so it is not a drop.
    always_comb begin
        w_drop_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_vec[i] = w_edge[i] && r_pend[i] && !(w_grant && (w_sel == CH_W'(i)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (r_ev_valid && ev_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key       <= '0;
            r_pend      <= '0;
            r_pend_type <= '0;
        end else begin
            if (clk_en) r_key <= key_on;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_edge[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_type[i] <= w_rise[i];
                end else if (w_grant && (w_sel == CH_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_valid   <= 1'b0;
            r_ev_channel <= '0;
            r_ev_key_on  <= 1'b0;
            r_ptr        <= '0;
        end else if (w_grant) begin
            r_ev_valid   <= 1'b1;
            r_ev_channel <= w_sel;
            r_ev_key_on  <= r_pend_type[w_sel];
        end else if (w_accept) begin
            r_ev_valid <= 1'b0;
            r_ptr      <= (r_ev_channel == CH_W'(NUM_CH - 1)) ? '0 : r_ev_channel + CH_W'(1);
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_ev_dropped <= 1'b0;
        else if (|w_drop_vec)   r_ev_dropped <= 1'b1;
        else if (dropped_clr)   r_ev_dropped <= 1'b0;
    end

    assign ev_valid   = r_ev_valid;
    assign ev_channel = r_ev_channel;
    assign ev_key_on  = r_ev_key_on;
    assign ev_dropped = r_ev_dropped;
    assign busy       = (|r_pend) || r_ev_valid;

endmodule

`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
// ============================================================================
// Module   : tb_key_event_scheduler
// Purpose  : Directed table-driven and sequence checks for key_event_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_scheduler;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [17:0] key_on;
    logic        ev_valid;
    logic        ev_ready;
    logic [4:0]  ev_channel;
    logic        ev_key_on;
    logic        ev_dropped;
    logic        dropped_clr;
    logic        busy;

    int n_vec;
    int n_bad;
    int n_acc;

    typedef struct {
        logic        rst;
        logic        en;
        logic [17:0] key;
        logic        rdy;
        logic        clr;
        logic        v;
        logic [4:0]  ch;
        logic        k;
        logic        d;
        logic        b;
    } vec_t;

    vec_t tbl[$];

    key_event_scheduler #(.NUM_CH(18), .CH_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .key_on     (key_on),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_channel (ev_channel),
        .ev_key_on  (ev_key_on),
        .ev_dropped (ev_dropped),
        .dropped_clr(dropped_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ev_valid && ev_ready) n_acc++;

    task automatic add(input logic rst, input logic en, input logic [17:0] key,
                       input logic rdy, input logic clr, input logic v,
                       input logic [4:0] ch, input logic k, input logic d, input logic b);
        vec_t e;
        e = '{rst, en, key, rdy, clr, v, ch, k, d, b};
        tbl.push_back(e);
    endtask

    task automatic apply(input logic en, input logic [17:0] key, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        clk_en      = en;
        key_on      = key;
        ev_ready    = rdy;
        dropped_clr = clr;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic v, input logic [4:0] ch,
                         input logic k, input logic d, input logic b);
        n_vec++;
        if (ev_valid !== v || ev_channel !== ch || ev_key_on !== k ||
            ev_dropped !== d || busy !== b) begin
            n_bad++;
            $display("FAIL %s: got valid=%0d ch=%0d key_on=%0d dropped=%0d busy=%0d, want valid=%0d ch=%0d key_on=%0d dropped=%0d busy=%0d",
                     name, ev_valid, ev_channel, ev_key_on, ev_dropped, busy, v, ch, k, d, b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clk_en      = 1'b0;
        key_on      = '0;
        ev_ready    = 1'b0;
        dropped_clr = 1'b0;
        reset       = 1'b1;
        #2;
        reset       = 1'b0;
    endtask

    initial begin
        int acc0;
        n_vec       = 0;
        n_bad       = 0;
        n_acc       = 0;
        reset       = 1'b1;
        clk_en      = 1'b0;
        key_on      = '0;
        ev_ready    = 1'b0;
        dropped_clr = 1'b0;

        // rst en key rdy clr | valid ch key_on dropped busy
        // single key-on then key-off on channel 5
        add(0, 1, 18'h00000, 1, 0,  0,  0, 0, 0, 0);
        add(0, 1, 18'h00020, 1, 0,  0,  0, 0, 0, 0);
        add(0, 0, 18'h00020, 1, 0,  0,  0, 0, 0, 1);
        add(0, 0, 18'h00020, 1, 0,  1,  5, 1, 0, 1);
        add(0, 1, 18'h00020, 1, 0,  0,  5, 1, 0, 0);
        add(0, 1, 18'h00000, 1, 0,  0,  5, 1, 0, 0);
        add(0, 0, 18'h00000, 1, 0,  0,  5, 1, 0, 1);
        add(0, 0, 18'h00000, 1, 0,  1,  5, 0, 0, 1);
        add(0, 0, 18'h00000, 1, 0,  0,  5, 0, 0, 0);
        // round robin 0,3,17 then 2,17 after wrap
        add(1, 1, 18'h20009, 1, 0,  0,  0, 0, 0, 0);
        add(0, 0, 18'h20009, 1, 0,  0,  0, 0, 0, 1);
        add(0, 0, 18'h20009, 1, 0,  1,  0, 1, 0, 1);
        add(0, 0, 18'h20009, 1, 0,  0,  0, 1, 0, 1);
        add(0, 0, 18'h20009, 1, 0,  1,  3, 1, 0, 1);
        add(0, 0, 18'h20009, 1, 0,  0,  3, 1, 0, 1);
        add(0, 0, 18'h20009, 1, 0,  1, 17, 1, 0, 1);
        add(0, 1, 18'h0000D, 1, 0,  0, 17, 1, 0, 0);
        add(0, 0, 18'h0000D, 1, 0,  0, 17, 1, 0, 1);
        add(0, 0, 18'h0000D, 1, 0,  1,  2, 1, 0, 1);
        add(0, 0, 18'h0000D, 1, 0,  0,  2, 1, 0, 1);
        add(0, 0, 18'h0000D, 1, 0,  1, 17, 0, 0, 1);
        add(0, 0, 18'h0000D, 1, 0,  0, 17, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (tbl[i].rst) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            clk_en      = tbl[i].en;
            key_on      = tbl[i].key;
            ev_ready    = tbl[i].rdy;
            dropped_clr = tbl[i].clr;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].ch, tbl[i].k, tbl[i].d, tbl[i].b);
        end

        // backpressure on channel 7
        do_reset();
        acc0 = n_acc;
        apply(1, 18'h00080, 0, 0); check("bp_idle", 0, 0, 0, 0, 0);
        apply(0, 18'h00080, 0, 0); check("bp_pend", 0, 0, 0, 0, 1);
        apply(0, 18'h00080, 0, 0); check("bp_offer", 1, 7, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            apply(0, 18'h00080, 0, 0);
            check($sformatf("bp_hold%0d", i), 1, 7, 1, 0, 1);
        end
        apply(0, 18'h00080, 1, 0); check("bp_accept", 1, 7, 1, 0, 1);
        apply(0, 18'h00080, 1, 0); check("bp_done", 0, 7, 1, 0, 0);
        apply(0, 18'h00080, 1, 0); check("bp_quiet", 0, 7, 1, 0, 0);
        n_vec++;
        if (n_acc - acc0 != 1) begin
            n_bad++;
            $display("FAIL bp_acc_count: got %0d acceptances, want 1", n_acc - acc0);
        end

        // channel 9 offered, channel 4 rises then falls -> drop
        apply(1, 18'h00280, 0, 0); check("dr_idle", 0, 7, 1, 0, 0);
        apply(0, 18'h00280, 0, 0); check("dr_pend", 0, 7, 1, 0, 1);
        apply(0, 18'h00280, 0, 0); check("dr_offer9", 1, 9, 1, 0, 1);
        apply(1, 18'h00290, 0, 0); check("dr_rise4", 1, 9, 1, 0, 1);
        apply(1, 18'h00280, 0, 0); check("dr_fall4", 1, 9, 1, 0, 1);
        apply(0, 18'h00280, 0, 0); check("dr_flag", 1, 9, 1, 1, 1);
        apply(0, 18'h00280, 1, 0); check("dr_acc9", 1, 9, 1, 1, 1);
        apply(0, 18'h00280, 1, 0); check("dr_gap", 0, 9, 1, 1, 1);
        apply(0, 18'h00280, 1, 0); check("dr_ev4_off", 1, 4, 0, 1, 1);
        apply(0, 18'h00280, 1, 1); check("dr_clr", 0, 4, 0, 1, 0);
        apply(0, 18'h00280, 1, 0); check("dr_cleared", 0, 4, 0, 0, 0);

        // edge on the channel currently offered
        apply(1, 18'h00284, 0, 0); check("eo_idle", 0, 4, 0, 0, 0);
        apply(0, 18'h00284, 0, 0); check("eo_pend", 0, 4, 0, 0, 1);
        apply(0, 18'h00284, 0, 0); check("eo_offer2", 1, 2, 1, 0, 1);
        apply(1, 18'h00280, 0, 0); check("eo_fall2", 1, 2, 1, 0, 1);
        apply(0, 18'h00280, 0, 0); check("eo_nodrop", 1, 2, 1, 0, 1);
        apply(0, 18'h00280, 1, 0); check("eo_acc", 1, 2, 1, 0, 1);
        apply(0, 18'h00280, 1, 0); check("eo_gap", 0, 2, 1, 0, 1);
        apply(0, 18'h00280, 1, 0); check("eo_second", 1, 2, 0, 0, 1);
        apply(0, 18'h00280, 1, 0); check("eo_done", 0, 2, 0, 0, 0);

        // reset while offering with three more pending
        apply(1, 18'h00003, 0, 0); check("rs_idle", 0, 2, 0, 0, 0);
        apply(0, 18'h00003, 0, 0); check("rs_pend", 0, 2, 0, 0, 1);
        apply(0, 18'h00003, 0, 0); check("rs_offer7", 1, 7, 0, 0, 1);
        reset = 1'b1;
        #1;
        check("rs_async", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        apply(1, 18'h00003, 1, 0); check("rs_after", 0, 0, 0, 0, 0);
        apply(0, 18'h00003, 1, 0); check("rs_pend01", 0, 0, 0, 0, 1);
        apply(0, 18'h00003, 1, 0); check("rs_ev0", 1, 0, 1, 0, 1);
        apply(0, 18'h00003, 1, 0); check("rs_gap", 0, 0, 1, 0, 1);
        apply(0, 18'h00003, 1, 0); check("rs_ev1", 1, 1, 1, 0, 1);
        apply(0, 18'h00003, 1, 0); check("rs_done", 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
